// File: rtl/vvp_pkg.sv
// Shared definitions for the vector-vector product sequencer: vvp modes,
// sequencer states and the vvp result-width helper.
package vvp_pkg;

  localparam logic [1:0] MODE_PM1  = 2'b00;
  localparam logic [1:0] MODE_P1   = 2'b01;
  localparam logic [1:0] MODE_M1   = 2'b10;
  localparam logic [1:0] MODE_ZERO = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LAST,
    OUT,
    FIN
  } state_t;

  // Width of the signed vvp sum for an N-wide product.
  function automatic int vvp_sw(input int n);
    return $clog2(n) + 2;
  endfunction

endpackage

// File: rtl/vvp_seq_acc.sv
// Row accumulator: sign-extends the vvp result and either loads it (first
// tile of a row), adds it, or holds. Wraps modulo 2^ACC_W.
module vvp_seq_acc
  import vvp_pkg::*;
#(
  parameter int SW    = vvp_sw(64),
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             add,
  input  logic [SW-1:0]    s,
  output logic [ACC_W-1:0] acc
);

  function automatic logic signed [ACC_W-1:0] sext(input logic [SW-1:0] v);
    return {{(ACC_W-SW){v[SW-1]}}, v};
  endfunction

  logic signed [ACC_W-1:0] acc_p2;

  // Stage p2: running sum, one cycle behind the vvp result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
    end else if (load) begin
      acc_p2 <= sext(s);
    end else if (add) begin
      acc_p2 <= acc_p2 + sext(s);
    end
  end

  assign acc = acc_p2;

endmodule

// File: rtl/vvp_seq.sv
// Matrix-vector job sequencer: walks rows x tiles through the weight/data
// memories, accumulates vvp results per row and emits one sum per row.
module vvp_seq
  import vvp_pkg::*;
#(
  parameter int N       = 64,
  parameter int ROWS_W  = 8,
  parameter int TILES_W = 8,
  parameter int ACC_W   = 24,
  parameter int WADDR_W = 10,
  parameter int DADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             cfg_mode,
  input  logic [ROWS_W-1:0]      cfg_rows,
  input  logic [TILES_W-1:0]     cfg_tiles,
  input  logic [WADDR_W-1:0]     cfg_wbase,
  input  logic [DADDR_W-1:0]     cfg_dbase,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             vvp_mode,
  output logic                   w_rd_en,
  output logic [WADDR_W-1:0]     w_addr,
  output logic                   d_rd_en,
  output logic [DADDR_W-1:0]     d_addr,
  input  logic [vvp_sw(N)-1:0]   vvp_s,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [ROWS_W-1:0]      out_row
);

  localparam int SW = vvp_sw(N);

  if (ACC_W < SW + TILES_W) begin : g_acc_w_check
    $error("vvp_seq: ACC_W must be at least SW + TILES_W");
  end

  state_t               state;
  logic                 rd_en;
  logic [ROWS_W-1:0]    row;
  logic [TILES_W-1:0]   tile;
  logic [ROWS_W-1:0]    rows_r;
  logic [TILES_W-1:0]   tiles_r;
  logic [DADDR_W-1:0]   dbase_r;
  logic                 vld_p1;
  logic                 first_p1;

  // Stage p0: control FSM and address issue. The weight pointer keeps
  // running across rows; the data pointer restarts at dbase for each row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vvp_mode  <= MODE_ZERO;
      rd_en     <= 1'b0;
      w_addr    <= '0;
      d_addr    <= '0;
      out_valid <= 1'b0;
      row       <= '0;
      tile      <= '0;
      rows_r    <= '0;
      tiles_r   <= '0;
      dbase_r   <= '0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
    end else begin
      done     <= 1'b0;
      vld_p1   <= rd_en;
      first_p1 <= rd_en && (tile == '0);
      case (state)
        IDLE: begin
          if (start) begin
            vvp_mode <= cfg_mode;
            rows_r   <= cfg_rows;
            tiles_r  <= cfg_tiles;
            dbase_r  <= cfg_dbase;
            busy     <= 1'b1;
            row      <= '0;
            tile     <= '0;
            if (cfg_rows == '0 || cfg_tiles == '0) begin
              state <= FIN;
            end else begin
              state  <= RUN;
              rd_en  <= 1'b1;
              w_addr <= cfg_wbase;
              d_addr <= cfg_dbase;
            end
          end
        end
        RUN: begin
          if (tile == tiles_r - TILES_W'(1)) begin
            state <= LAST;
            rd_en <= 1'b0;
          end else begin
            tile   <= tile + TILES_W'(1);
            w_addr <= w_addr + WADDR_W'(1);
            d_addr <= d_addr + DADDR_W'(1);
          end
        end
        LAST: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == rows_r - ROWS_W'(1)) begin
              state <= FIN;
            end else begin
              row    <= row + ROWS_W'(1);
              tile   <= '0;
              state  <= RUN;
              rd_en  <= 1'b1;
              w_addr <= w_addr + WADDR_W'(1);
              d_addr <= dbase_r;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign w_rd_en = rd_en;
  assign d_rd_en = rd_en;
  assign out_row = row;

  // Stage p1 -> p2: the vvp result of the previous cycle's issue is
  // folded into the row accumulator.
  vvp_seq_acc #(
    .SW    (SW),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (vld_p1 && first_p1),
    .add  (vld_p1 && !first_p1),
    .s    (vvp_s),
    .acc  (out_data)
  );

endmodule

// File: tb/tb_vvp_seq.sv
// Directed bench for vvp_seq: a behavioural memory+vvp stand-in feeds vvp_s,
// a scoreboard queue holds expected addresses and row results.
module tb_vvp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_rows = '0;
  logic [7:0]  cfg_tiles = '0;
  logic [9:0]  cfg_wbase = '0;
  logic [7:0]  cfg_dbase = '0;
  logic        busy, done;
  logic [1:0]  vvp_mode;
  logic        w_rd_en, d_rd_en;
  logic [9:0]  w_addr;
  logic [7:0]  d_addr;
  logic [7:0]  vvp_s;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic [7:0]  out_row;

  vvp_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
    .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles), .cfg_wbase(cfg_wbase),
    .cfg_dbase(cfg_dbase), .busy(busy), .done(done), .vvp_mode(vvp_mode),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .d_rd_en(d_rd_en), .d_addr(d_addr),
    .vvp_s(vvp_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row)
  );

  always #5 clk = ~clk;

  // Memories hold uniform vectors: one weight bit and one data sign per address.
  logic wbits [1024];
  int   dvals [256];
  logic wq = 1'b0;
  int   dq = 0;

  always @(posedge clk) begin
    if (w_rd_en) wq <= wbits[w_addr];
    if (d_rd_en) dq <= dvals[d_addr];
  end

  function automatic logic [7:0] model_s(input logic [1:0] m, input logic wb, input int dv);
    int wv;
    case (m)
      2'b00:   wv = wb ? -1 : 1;
      2'b01:   wv = wb ? 1 : 0;
      2'b10:   wv = wb ? -1 : 0;
      default: wv = 0;
    endcase
    return 8'(64 * wv * dv);
  endfunction

  assign vvp_s = model_s(vvp_mode, wq, dq);

  typedef struct {
    longint data;
    longint row;
  } res_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     seen_done = 0;
  int     exp_done = 0;
  longint wq_exp[$];
  longint dq_exp[$];
  res_t   rq_exp[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_job(input int wb, input int db, input int rows, input int tiles);
    for (int r = 0; r < rows; r++)
      for (int t = 0; t < tiles; t++) begin
        wq_exp.push_back((wb + r * tiles + t) % 1024);
        dq_exp.push_back((db + t) % 256);
      end
  endtask

  task automatic expect_out(input longint data, input longint row);
    res_t e;
    e.data = data;
    e.row  = row;
    rq_exp.push_back(e);
  endtask

  // Leaves the bench 1 ns after the edge that sampled start (first busy cycle).
  task automatic start_job(input logic [1:0] m, input logic [7:0] r, input logic [7:0] t,
                           input logic [9:0] wb, input logic [7:0] db);
    cfg_mode = m; cfg_rows = r; cfg_tiles = t; cfg_wbase = wb; cfg_dbase = db;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = ~m; cfg_rows = 8'hA5; cfg_tiles = 8'h5A; cfg_wbase = 10'h155; cfg_dbase = 8'h33;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_pulse", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    check("valid_rise", out_valid, 1);
  endtask

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (w_rd_en) begin
          if (wq_exp.size() == 0) check("w_addr_unexpected_read", w_addr, -1);
          else check("w_addr", w_addr, wq_exp.pop_front());
        end
        if (d_rd_en) begin
          if (dq_exp.size() == 0) check("d_addr_unexpected_read", d_addr, -1);
          else check("d_addr", d_addr, dq_exp.pop_front());
        end
        if (out_valid) begin
          check("no_w_read_in_out", w_rd_en, 0);
          check("no_d_read_in_out", d_rd_en, 0);
        end
        if (out_valid && out_ready) begin
          if (rq_exp.size() == 0) begin
            check("out_unexpected", $signed(out_data), -99999);
          end else begin
            e = rq_exp.pop_front();
            check("out_data", $signed(out_data), e.data);
            check("out_row", out_row, e.row);
          end
        end
        if (done) seen_done++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 1024; i++) wbits[i] = 1'b0;
    for (int i = 0; i < 256; i++) dvals[i] = 1;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_rd_en", w_rd_en, 0);
    check("rst_d_rd_en", d_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_vvp_mode", vvp_mode, 3);
    check("rst_w_addr", w_addr, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Job 1: PM1, 1 row x 2 tiles, W=0 D=+1 -> 64+64.
    wbits[0] = 1'b0; wbits[1] = 1'b0; dvals[0] = 1; dvals[1] = 1;
    expect_job(0, 0, 1, 2);
    expect_out(128, 0);
    exp_done++;
    start_job(2'b00, 8'd1, 8'd2, 10'd0, 8'd0);
    check("j1_busy", busy, 1);
    check("j1_mode", vvp_mode, 0);
    check("j1_valid_c1", out_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    check("j1_valid_c3", out_valid, 0);
    @(posedge clk); #1;
    check("j1_valid_c4", out_valid, 1);
    wait_done(10);
    check("j1_busy_after", busy, 0);

    // Job 2: P1, 2 rows x 3 tiles; row0 W=1 D=-1, row1 W=0.
    for (int i = 16; i < 19; i++) wbits[i] = 1'b1;
    for (int i = 19; i < 22; i++) wbits[i] = 1'b0;
    for (int i = 4; i < 7; i++) dvals[i] = -1;
    expect_job(16, 4, 2, 3);
    expect_out(-192, 0);
    expect_out(0, 1);
    exp_done++;
    start_job(2'b01, 8'd2, 8'd3, 10'd16, 8'd4);
    check("j2_mode_latched", vvp_mode, 1);
    wait_done(40);

    // Job 3: backpressure on row 0, single-tile rows.
    wbits[100] = 1'b1; wbits[101] = 1'b0; dvals[200] = -1;
    expect_job(100, 200, 2, 1);
    expect_out(64, 0);
    expect_out(-64, 1);
    exp_done++;
    out_ready = 1'b0;
    start_job(2'b00, 8'd2, 8'd1, 10'd100, 8'd200);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", $signed(out_data), 64);
      check("bp_row", out_row, 0);
      check("bp_no_read", w_rd_en, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_row1_read", w_rd_en, 1);
    check("bp_row1_addr", w_addr, 101);
    check("bp_valid_drop", out_valid, 0);
    wait_done(20);

    // Zero rows and zero tiles: straight to done, no reads, no outputs.
    exp_done++;
    start_job(2'b00, 8'd0, 8'd4, 10'd7, 8'd7);
    check("zr_busy", busy, 1);
    check("zr_done_c1", done, 0);
    @(posedge clk); #1;
    check("zr_done_c2", done, 1);
    check("zr_busy_c2", busy, 0);
    @(posedge clk); #1;
    exp_done++;
    start_job(2'b01, 8'd3, 8'd0, 10'd7, 8'd7);
    @(posedge clk); #1;
    check("zt_done_c2", done, 1);
    @(posedge clk); #1;

    // Reset in the middle of a job.
    expect_job(16, 4, 2, 3);
    start_job(2'b01, 8'd2, 8'd3, 10'd16, 8'd4);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_w_rd_en", w_rd_en, 0);
    check("mid_rst_d_rd_en", d_rd_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mode", vvp_mode, 3);
    check("mid_rst_w_addr", w_addr, 0);
    check("mid_rst_d_addr", d_addr, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_row", out_row, 0);
    wq_exp.delete();
    dq_exp.delete();
    rq_exp.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);

    // Fresh job after reset: PM1, W=0,1,0 D=+1 -> 64-64+64.
    wbits[5] = 1'b0; wbits[6] = 1'b1; wbits[7] = 1'b0;
    for (int i = 10; i < 13; i++) dvals[i] = 1;
    expect_job(5, 10, 1, 3);
    expect_out(64, 0);
    exp_done++;
    start_job(2'b00, 8'd1, 8'd3, 10'd5, 8'd10);
    wait_done(20);

    // Weight address wrap and an ignored second start while busy.
    wbits[1023] = 1'b1; wbits[0] = 1'b1; dvals[50] = 1; dvals[51] = 1;
    expect_job(1023, 50, 1, 2);
    expect_out(-128, 0);
    exp_done++;
    start_job(2'b10, 8'd1, 8'd2, 10'd1023, 8'd50);
    check("wrap_first_addr", w_addr, 1023);
    cfg_mode = 2'b00; cfg_rows = 8'd4; cfg_tiles = 8'd3; cfg_wbase = 10'd3; cfg_dbase = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("wrap_second_addr", w_addr, 0);
    check("ignored_start_mode", vvp_mode, 2);
    wait_done(20);

    repeat (4) @(posedge clk);
    #1;
    check("done_count", seen_done, exp_done);
    check("w_queue_drained", wq_exp.size(), 0);
    check("d_queue_drained", dq_exp.size(), 0);
    check("out_queue_drained", rq_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
